reset_sequencer: RTL and testbench

- Parametrised successor to the single-domain PLL-lock reset generator in the top level.
- Synchronises the PLL lock input, requires a run of consecutive locked cycles, then releases CHANNELS active-high reset outputs one at a time with a programmable gap.
- Re-sequences on lock loss or software request.
- Sits between the pll/clock source and the icicle core and peripheral reset domains.

---
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock: synchronise lock, hold for a locked run,
// then drop rst_out bits one at a time. Optional lock watchdog: RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int CHANNELS     = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                locked_async,
    input  logic                sw_reset_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                all_released,
    output logic [7:0]          restart_count
`ifdef RESET_SEQ_WDT_EN
    ,
    output logic                lock_fail
`endif
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W   = $clog2(STAGE_GAP) + 1;
    localparam int STAGE_W = $clog2(CHANNELS) + 1;
    localparam logic [CHANNELS-1:0] ALL_ONES = {CHANNELS{1'b1}};

    // Reject parameter values the sequencing cannot honour.
    if (CHANNELS < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || SYNC_STAGES < 2 ||
        LOCK_TIMEOUT < 1) begin : g_param_check
        $error("reset_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_sync_s;
    logic                   abort_s;

    state_t                 state_r, state_s;
    logic [HOLD_W-1:0]      hold_cnt_r, hold_cnt_s;
    logic [GAP_W-1:0]       gap_cnt_r, gap_cnt_s;
    logic [STAGE_W-1:0]     stage_r, stage_s;
    logic [CHANNELS-1:0]    rst_out_r, rst_out_s;
    logic                   all_released_r, all_released_s;
    logic [7:0]             restart_r, restart_s;

    assign locked_sync_s = sync_r[SYNC_STAGES-1];
    assign abort_s       = ~locked_sync_s | sw_reset_req;

    // Lock synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked_async};
        end
    end

    // Sequencer next-state and output computation.
    always_comb begin
        state_s        = state_r;
        hold_cnt_s     = hold_cnt_r;
        gap_cnt_s      = gap_cnt_r;
        stage_s        = stage_r;
        rst_out_s      = rst_out_r;
        all_released_s = all_released_r;
        restart_s      = restart_r;

        case (state_r)
            ST_HOLD: begin
                rst_out_s      = ALL_ONES;
                all_released_s = 1'b0;
                if (abort_s) begin
                    hold_cnt_s = {HOLD_W{1'b0}};
                end else if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_cnt_s = {HOLD_W{1'b0}};
                    rst_out_s  = ALL_ONES << 1;
                    stage_s    = STAGE_W'(1);
                    gap_cnt_s  = {GAP_W{1'b0}};
                    if (CHANNELS == 1) begin
                        state_s        = ST_RUN;
                        all_released_s = 1'b1;
                    end else begin
                        state_s        = ST_RELEASE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (abort_s) begin
                    // Abort wins over any release scheduled on this edge.
                    state_s        = ST_HOLD;
                    rst_out_s      = ALL_ONES;
                    all_released_s = 1'b0;
                    hold_cnt_s     = {HOLD_W{1'b0}};
                    gap_cnt_s      = {GAP_W{1'b0}};
                    stage_s        = {STAGE_W{1'b0}};
                    restart_s      = (restart_r == 8'hFF) ? restart_r : restart_r + 8'd1;
                end else if (state_r == ST_RUN) begin
                    state_s = ST_RUN;
                end else if (gap_cnt_r == GAP_W'(STAGE_GAP - 1)) begin
                    rst_out_s = rst_out_r & ~(CHANNELS'(1) << stage_r);
                    gap_cnt_s = {GAP_W{1'b0}};
                    stage_s   = stage_r + STAGE_W'(1);
                    if (stage_r == STAGE_W'(CHANNELS - 1)) begin
                        state_s        = ST_RUN;
                        all_released_s = 1'b1;
                    end else begin
                        state_s        = ST_RELEASE;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_s        = ST_HOLD;
                rst_out_s      = ALL_ONES;
                all_released_s = 1'b0;
                hold_cnt_s     = {HOLD_W{1'b0}};
                gap_cnt_s      = {GAP_W{1'b0}};
                stage_s        = {STAGE_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_HOLD;
            hold_cnt_r     <= {HOLD_W{1'b0}};
            gap_cnt_r      <= {GAP_W{1'b0}};
            stage_r        <= {STAGE_W{1'b0}};
            rst_out_r      <= ALL_ONES;
            all_released_r <= 1'b0;
            restart_r      <= 8'd0;
        end else begin
            state_r        <= state_s;
            hold_cnt_r     <= hold_cnt_s;
            gap_cnt_r      <= gap_cnt_s;
            stage_r        <= stage_s;
            rst_out_r      <= rst_out_s;
            all_released_r <= all_released_s;
            restart_r      <= restart_s;
        end
    end

    assign rst_out       = rst_out_r;
    assign all_released  = all_released_r;
    assign restart_count = restart_r;

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = $clog2(LOCK_TIMEOUT) + 1;

    logic [WDT_W-1:0] wdt_cnt_r, wdt_cnt_s;
    logic             lock_fail_r, lock_fail_s;
    logic             wdt_hit_s;

    assign wdt_hit_s = (state_r == ST_HOLD) && (wdt_cnt_r == WDT_W'(LOCK_TIMEOUT - 1));

    // Watchdog counts time spent in HOLD; the failure flag is sticky.
    always_comb begin
        wdt_cnt_s   = {WDT_W{1'b0}};
        lock_fail_s = lock_fail_r | wdt_hit_s;
        if (state_r == ST_HOLD && state_s == ST_HOLD) begin
            wdt_cnt_s = wdt_hit_s ? wdt_cnt_r : wdt_cnt_r + WDT_W'(1);
        end else begin
            wdt_cnt_s = {WDT_W{1'b0}};
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_cnt_r   <= {WDT_W{1'b0}};
            lock_fail_r <= 1'b0;
        end else begin
            wdt_cnt_r   <= wdt_cnt_s;
            lock_fail_r <= lock_fail_s;
        end
    end

    assign lock_fail = lock_fail_r;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing scenarios plus
// randomized lock/request stimulus against a streak-based reference model.
module tb_reset_sequencer;

    localparam int CH   = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int SYNC = 2;
    localparam int LT   = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          locked_async = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic [CH-1:0] rst_out;
    logic          all_released;
    logic [7:0]    restart_count;
`ifdef RESET_SEQ_WDT_EN
    logic          lock_fail;
`endif

    reset_sequencer #(
        .CHANNELS     (CH),
        .HOLD_CYCLES  (HOLD),
        .STAGE_GAP    (GAP),
        .SYNC_STAGES  (SYNC),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .locked_async  (locked_async),
        .sw_reset_req  (sw_reset_req),
        .rst_out       (rst_out),
        .all_released  (all_released),
        .restart_count (restart_count)
`ifdef RESET_SEQ_WDT_EN
        ,
        .lock_fail     (lock_fail)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the release progress is a pure function of how many
    // consecutive "good" edges (synchronised lock, no request) have elapsed.
    logic sync_q[$];
    int   streak;
    int   m_restarts;
    int   m_hold_edges;
    logic m_lock_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sync_q.delete();
        for (int i = 0; i < SYNC; i++) sync_q.push_back(1'b0);
        streak       = 0;
        m_restarts   = 0;
        m_hold_edges = 0;
        m_lock_fail  = 1'b0;
    endtask

    function automatic int released_of(input int s);
        int n;
        if (s < HOLD) return 0;
        n = 1 + (s - HOLD) / GAP;
        return (n > CH) ? CH : n;
    endfunction

    task automatic model_edge(input logic a, input logic sw);
        logic ls;
        bit   pre_hold, post_hold;
        ls = sync_q.pop_front();
        sync_q.push_back(a);
        pre_hold = (streak < HOLD);
        if (ls && !sw) begin
            if (streak < 1000000) streak++;
        end else begin
            if (!pre_hold && m_restarts < 255) m_restarts++;
            streak = 0;
        end
        post_hold = (streak < HOLD);
        if (pre_hold && m_hold_edges == LT - 1) m_lock_fail = 1'b1;
        if (pre_hold && post_hold) begin
            if (m_hold_edges < LT - 1) m_hold_edges++;
        end else begin
            m_hold_edges = 0;
        end
    endtask

    task automatic tick(input logic a, input logic sw);
        logic [CH-1:0] exp_rst;
        int            n;
        locked_async = a;
        sw_reset_req = sw;
        @(posedge clk);
        model_edge(a, sw);
        #1;
        n       = released_of(streak);
        exp_rst = {CH{1'b1}};
        exp_rst = exp_rst << n;
        check_eq("model_rst_out", rst_out, exp_rst);
        check_eq("model_all_released", all_released, (n == CH) ? 1 : 0);
        check_eq("model_restart_count", restart_count, m_restarts);
`ifdef RESET_SEQ_WDT_EN
        check_eq("model_lock_fail", lock_fail, m_lock_fail);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_out", rst_out, 4'b1111);
        check_eq("async_restart_count", restart_count, 8'd0);
        check_eq("async_all_released", all_released, 1'b0);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int pct;
        model_reset();
        locked_async = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("por_rst_out", rst_out, 4'b1111);
        check_eq("por_all_released", all_released, 1'b0);
        check_eq("por_restart_count", restart_count, 8'd0);
        reset = 1'b1;

        // Nominal power-on sequence, then a one-cycle lock loss while running.
        for (int e = 1; e <= 75; e++) begin
            tick((e == 40) ? 1'b0 : 1'b1, 1'b0);
            case (e)
                17: check_eq("nom_e17", rst_out, 4'b1111);
                18: check_eq("nom_e18", rst_out, 4'b1110);
                22: check_eq("nom_e22", rst_out, 4'b1100);
                26: check_eq("nom_e26", rst_out, 4'b1000);
                30: begin
                    check_eq("nom_e30_rst", rst_out, 4'b0000);
                    check_eq("nom_e30_all", all_released, 1'b1);
                    check_eq("nom_e30_restart", restart_count, 8'd0);
                end
                41: check_eq("loss_e41", rst_out, 4'b0000);
                42: begin
                    check_eq("loss_e42_rst", rst_out, 4'b1111);
                    check_eq("loss_e42_restart", restart_count, 8'd1);
                end
                57: check_eq("loss_e57", rst_out, 4'b1111);
                58: check_eq("loss_e58", rst_out, 4'b1110);
                72: check_eq("loss_e72_all", all_released, 1'b1);
                default: ;
            endcase
        end
        async_reset();

        // Lock glitch during HOLD restarts the hold count.
        for (int e = 1; e <= 32; e++) begin
            tick((e == 10) ? 1'b0 : 1'b1, 1'b0);
            case (e)
                18: check_eq("glitch_e18", rst_out, 4'b1111);
                27: check_eq("glitch_e27", rst_out, 4'b1111);
                28: check_eq("glitch_e28", rst_out, 4'b1110);
                default: ;
            endcase
        end
        async_reset();

        // Software request mid-release.
        for (int e = 1; e <= 44; e++) begin
            tick(1'b1, (e == 24) ? 1'b1 : 1'b0);
            case (e)
                22: check_eq("sw_e22", rst_out, 4'b1100);
                24: begin
                    check_eq("sw_e24_rst", rst_out, 4'b1111);
                    check_eq("sw_e24_restart", restart_count, 8'd1);
                end
                39: check_eq("sw_e39", rst_out, 4'b1111);
                40: check_eq("sw_e40", rst_out, 4'b1110);
                default: ;
            endcase
        end

        // Randomized lock quality and sporadic software requests.
        for (int blk = 0; blk < 24; blk++) begin
            case ($urandom_range(0, 3))
                0: pct = 0;
                1: pct = 1;
                2: pct = 4;
                default: pct = 30;
            endcase
            for (int i = 0; i < 100; i++) begin
                tick(($urandom_range(0, 99) >= pct) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
            end
        end

        // Drive enough aborts to saturate the restart counter.
        for (int r = 0; r < 270; r++) begin
            repeat (17 + $urandom_range(0, 3)) tick(1'b1, 1'b0);
            tick(1'b1, 1'b1);
        end
        check_eq("restart_saturated", restart_count, 8'd255);
        async_reset();

`ifdef RESET_SEQ_WDT_EN
        // Watchdog fires after LT edges without lock and stays set.
        for (int e = 1; e <= 140; e++) begin
            tick((e <= 100) ? 1'b0 : 1'b1, 1'b0);
            case (e)
                99:  check_eq("wdt_e99", lock_fail, 1'b0);
                100: check_eq("wdt_e100", lock_fail, 1'b1);
                140: begin
                    check_eq("wdt_e140_all", all_released, 1'b1);
                    check_eq("wdt_e140_fail", lock_fail, 1'b1);
                end
                default: ;
            endcase
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
